microwave_ctrl: RTL and testbench

Sequencing controller for the microwave's M:SS countdown timer. Accepts keypad digits and shift-loads them into the timer. Runs the cook cycle by issuing one timer-decrement enable per second and drives the magnetron. Handles door-open pause, stop/clear and the end-of-cook alert. Sits between the debounced front-panel inputs and the three-digit timer (units mod-10, tens mod-6, minutes mod-10).

---
 rtl/mwave_pkg.sv | 26 ++
 rtl/sec_prescaler.sv | 36 +++
 rtl/microwave_ctrl.sv | 153 +++++++++++++++
 tb/tb_microwave_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mwave_pkg.sv
// Shared definitions for the microwave cook controller: state encoding,
// keypad entry limits and the digit acceptance rule.
package mwave_pkg;

  localparam int DIGIT_W        = 4;
  localparam int MAX_DIGITS     = 3;
  localparam int MAX_TENS_DIGIT = 5;
  localparam int CNT_W          = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET   = 3'd1;
  localparam logic [2:0] ST_COOK  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // A key is taken if it is a BCD digit, there is room for it, and the digit
  // it pushes into the tens-of-seconds position is a legal tens digit.
  function automatic logic digit_ok(input logic [CNT_W-1:0]   cnt,
                                    input logic [DIGIT_W-1:0] d,
                                    input logic [DIGIT_W-1:0] prev);
    digit_ok = (d <= DIGIT_W'(9)) &&
               (cnt < CNT_W'(MAX_DIGITS)) &&
               ((cnt == '0) || (prev <= DIGIT_W'(MAX_TENS_DIGIT)));
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Seconds prescaler: modulo-TICKS counter with synchronous clear and enable.
// wrap pulses on the last tick of each second; secs counts completed seconds.
module sec_prescaler #(
  parameter int TICKS = 100,
  parameter int SEC_W = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr,
  input  logic             en,
  output logic             wrap,
  output logic [SEC_W-1:0] secs
);

  localparam int CW = $clog2(TICKS);

  logic [CW-1:0] cnt;

  assign wrap = en && (cnt == CW'(TICKS - 1));

  // Tick and second counters; clear wins over counting.
  always_ff @(posedge clk) begin
    if (clr || sclr) begin
      cnt  <= '0;
      secs <= '0;
    end else if (en) begin
      if (wrap) begin
        cnt  <= '0;
        secs <= secs + SEC_W'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave cook sequencer: keypad shift-load, once-per-second timer
// decrement, magnetron drive, door pause, stop/clear and end-of-cook.
// Optional end-of-cook alert enabled by defining MWAVE_DONE_BEEP_EN.
//
// state | meaning
// IDLE  | no digits entered, waiting for keys
// SET   | digits being entered, waiting for start
// COOK  | magnetron on, timer decremented once per second
// PAUSE | door opened or stop pressed during cook, timer held
// DONE  | timer reached zero; alert (if enabled) then back to IDLE
module microwave_ctrl
  import mwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int BEEP_SECS     = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               start,
  input  logic               stop_clear,
  input  logic               door_closed,
  input  logic               timer_zero,
  output logic [DIGIT_W-1:0] timer_data,
  output logic               timer_loadn,
  output logic               timer_clrn,
  output logic               timer_en,
  output logic               mag_on,
  output logic               beep
);

  localparam int SEC_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic             do_load, do_clear;
  logic             pre_sclr, pre_en, wrap;

`ifdef MWAVE_DONE_BEEP_EN
  logic [SEC_W-1:0] beep_secs;
  logic             door_q;
`else
  logic [SEC_W-1:0] beep_secs_unused;
`endif

  // The prescaler restarts on every state change so each entry to COOK or
  // DONE begins a fresh second.
  assign pre_en   = (state == ST_COOK) || (state == ST_DONE);
  assign pre_sclr = (state_nxt != state);

  sec_prescaler #(
    .TICKS (TICKS_PER_SEC),
    .SEC_W (SEC_W)
  ) u_presc (
    .clk  (clk),
    .clr  (clr),
    .sclr (pre_sclr),
    .en   (pre_en),
    .wrap (wrap),
`ifdef MWAVE_DONE_BEEP_EN
    .secs (beep_secs)
`else
    .secs (beep_secs_unused)
`endif
  );

  // Next state and one-cycle load/clear requests, highest-priority input first.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_clear  = 1'b0;
    case (state)
      ST_IDLE, ST_SET: begin
        if (stop_clear) begin
          if (state == ST_SET) begin
            do_clear  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (start) begin
          if ((state == ST_SET) && door_closed && !timer_zero)
            state_nxt = ST_COOK;
        end else if (key_valid && digit_ok(count, key_digit, timer_data)) begin
          do_load   = 1'b1;
          state_nxt = ST_SET;
        end
      end
      ST_COOK: begin
        if (!door_closed || stop_clear)
          state_nxt = ST_PAUSE;
        else if (timer_zero)
          state_nxt = ST_DONE;
      end
      ST_PAUSE: begin
        if (stop_clear) begin
          do_clear  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (start && door_closed && !timer_zero) begin
          state_nxt = ST_COOK;
        end
      end
      ST_DONE: begin
`ifdef MWAVE_DONE_BEEP_EN
        if (stop_clear || (door_closed != door_q) ||
            (wrap && (beep_secs == SEC_W'(BEEP_SECS - 1))))
          state_nxt = ST_IDLE;
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, digit count and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= ST_IDLE;
      count       <= '0;
      timer_data  <= '0;
      timer_loadn <= 1'b1;
      timer_clrn  <= 1'b0;
      timer_en    <= 1'b0;
      mag_on      <= 1'b0;
      beep        <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer_loadn <= !do_load;
      timer_clrn  <= !do_clear;
      timer_en    <= wrap && (state == ST_COOK) && (state_nxt == ST_COOK);
      mag_on      <= (state_nxt == ST_COOK);
      if (do_load)
        timer_data <= key_digit;
      if (do_clear || (state_nxt == ST_DONE))
        count <= '0;
      else if (do_load)
        count <= count + CNT_W'(1);
`ifdef MWAVE_DONE_BEEP_EN
      beep <= (state_nxt == ST_DONE);
`else
      beep <= 1'b0;
`endif
    end
  end

`ifdef MWAVE_DONE_BEEP_EN
  // Door level one cycle back, to spot a door transition during the alert.
  always_ff @(posedge clk) begin
    door_q <= door_closed;
  end
`endif

endmodule

// File: tb/tb_microwave_ctrl.sv
// Testbench for microwave_ctrl: behavioural cook-controller model plus a
// three-digit BCD timer, directed scenarios and randomized front-panel input.
module tb_microwave_ctrl;

  localparam int T = 4;
  localparam int B = 3;

  logic       clk = 1'b0;
  logic       clr, key_valid, start, stop_clear, door_closed;
  logic [3:0] key_digit;
  logic       timer_zero;
  logic [3:0] timer_data;
  logic       timer_loadn, timer_clrn, timer_en, mag_on, beep;

  always #5 clk = ~clk;

  microwave_ctrl #(.TICKS_PER_SEC(T), .BEEP_SECS(B)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
    .timer_zero(timer_zero), .timer_data(timer_data), .timer_loadn(timer_loadn),
    .timer_clrn(timer_clrn), .timer_en(timer_en), .mag_on(mag_on), .beep(beep)
  );

  // ---------------- three-digit timer (M:SS) ----------------
  logic [3:0] tm_u = 0, tm_t = 0, tm_m = 0;
  assign timer_zero = (tm_u == 0) && (tm_t == 0) && (tm_m == 0);

  always @(posedge clk) begin
    if (timer_clrn === 1'b0) begin
      tm_u <= 0; tm_t <= 0; tm_m <= 0;
    end else if (timer_loadn === 1'b0) begin
      tm_m <= tm_t; tm_t <= tm_u; tm_u <= timer_data;
    end else if (timer_en === 1'b1 && !timer_zero) begin
      if (tm_u != 0) tm_u <= tm_u - 1;
      else begin
        tm_u <= 9;
        if (tm_t != 0) tm_t <= tm_t - 1;
        else begin tm_t <= 5; tm_m <= tm_m - 1; end
      end
    end
  end

  function automatic int timer_val();
    return tm_m * 100 + tm_t * 10 + tm_u;
  endfunction

  // ---------------- checking ----------------
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_SET, M_COOK, M_PAUSE, M_DONE} mode_t;
  mode_t      md = M_IDLE;
  int         ndig = 0, last = 0, cook_cyc = 0, beep_cyc = 0;
  bit         door_prev = 1'b1, started = 1'b0;
  logic [3:0] e_data = 0;
  bit         e_loadn = 1, e_clrn = 0, e_en = 0, e_mag = 0, e_beep = 0;

  always @(posedge clk) begin : model
    bit tz;
    tz = timer_zero;
    e_loadn = 1; e_clrn = 1; e_en = 0;
    if (clr) begin
      md = M_IDLE; ndig = 0; e_data = 0; e_clrn = 0;
    end else begin
      case (md)
        M_IDLE, M_SET: begin
          if (stop_clear) begin
            if (md == M_SET) begin e_clrn = 0; ndig = 0; md = M_IDLE; end
          end else if (start) begin
            if (md == M_SET && door_closed && !tz) begin md = M_COOK; cook_cyc = 0; end
          end else if (key_valid && key_digit <= 9 && ndig < 3 && (ndig == 0 || last <= 5)) begin
            e_data = key_digit; e_loadn = 0; ndig++; last = key_digit; md = M_SET;
          end
        end
        M_COOK: begin
          if (!door_closed || stop_clear) md = M_PAUSE;
          else if (tz) begin md = M_DONE; ndig = 0; beep_cyc = 0; end
          else begin
            cook_cyc++;
            if (cook_cyc % T == 0) e_en = 1;
          end
        end
        M_PAUSE: begin
          if (stop_clear) begin e_clrn = 0; ndig = 0; md = M_IDLE; end
          else if (start && door_closed && !tz) begin md = M_COOK; cook_cyc = 0; end
        end
        M_DONE: begin
`ifdef MWAVE_DONE_BEEP_EN
          beep_cyc++;
          if (stop_clear || door_closed != door_prev || beep_cyc >= B * T) md = M_IDLE;
`else
          md = M_IDLE;
`endif
        end
        default: md = M_IDLE;
      endcase
    end
    e_mag = (md == M_COOK);
`ifdef MWAVE_DONE_BEEP_EN
    e_beep = (md == M_DONE);
`else
    e_beep = 0;
`endif
    door_prev = door_closed;
    started = 1'b1;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("timer_data",  timer_data,  e_data);
      chk("timer_loadn", timer_loadn, e_loadn);
      chk("timer_clrn",  timer_clrn,  e_clrn);
      chk("timer_en",    timer_en,    e_en);
      chk("mag_on",      mag_on,      e_mag);
      chk("beep",        beep,        e_beep);
    end
  end

  // Observers: load strobes, decrement spacing, alert length.
  int   ncyc = 0, last_evt = 0, en_cnt = 0, gap_bad = 0, beep_cnt = 0;
  bit   mag_prev = 0;
  int   ld_q[$];

  always @(negedge clk) begin
    ncyc++;
    if (mag_on === 1'b1 && !mag_prev) last_evt = ncyc;
    if (timer_en === 1'b1) begin
      en_cnt++;
      if (mag_on !== 1'b1 || ncyc - last_evt != T) gap_bad++;
      last_evt = ncyc;
    end
    mag_prev = (mag_on === 1'b1);
    if (beep === 1'b1) beep_cnt++;
    if (timer_loadn === 1'b0) ld_q.push_back(int'(timer_data));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic key(input int d);
    key_valid = 1; key_digit = 4'(d); cyc(1);
    key_valid = 0; cyc(1);
  endtask

  task automatic do_start();
    start = 1; cyc(1); start = 0;
  endtask

  task automatic do_stop();
    stop_clear = 1; cyc(1); stop_clear = 0;
  endtask

  task automatic wait_mag(input logic val, input int limit, input string nm);
    int n = 0;
    while (mag_on !== val && n < limit) begin cyc(1); n++; end
    chk(nm, mag_on, val);
  endtask

  task automatic wait_beep(input logic val, input int limit, input string nm);
    int n = 0;
    while (beep !== val && n < limit) begin cyc(1); n++; end
    chk(nm, beep, val);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n0, e0, b0, v;
    clr = 1; key_valid = 0; key_digit = 0; start = 0; stop_clear = 0; door_closed = 1;
    cyc(3);
    chk("rst_loadn", timer_loadn, 1);
    chk("rst_en",    timer_en,    0);
    chk("rst_mag",   mag_on,      0);
    chk("rst_beep",  beep,        0);
    chk("rst_data",  timer_data,  0);
    chk("rst_clrn",  timer_clrn,  0);
    clr = 0;
    cyc(1);
    chk("rst_clrn_release", timer_clrn, 1);

    // 1,3,0 then a rejected 4th key; cook 1:30 to completion
    n0 = ld_q.size();
    key(1); key(3); key(0); key(4);
    chk("load_count_130", ld_q.size() - n0, 3);
    chk("load0", ld_q[n0],     1);
    chk("load1", ld_q[n0 + 1], 3);
    chk("load2", ld_q[n0 + 2], 0);
    chk("timer_130", timer_val(), 130);
    e0 = en_cnt; b0 = beep_cnt;
    do_start();
    chk("mag_after_start", mag_on, 1);
    wait_mag(0, 600, "cook_end_timeout");
    cyc(16);
    chk("decrements_90", en_cnt - e0, 90);
    chk("timer_zero_end", timer_val(), 0);
`ifdef MWAVE_DONE_BEEP_EN
    chk("beep_len_12", beep_cnt - b0, 12);
`else
    chk("beep_len_0", beep_cnt - b0, 0);
`endif

    // 7 then 2: 2 rejected. Clear, then 5,9 accepted and 3 rejected.
    n0 = ld_q.size();
    key(7); key(2);
    chk("load_count_72", ld_q.size() - n0, 1);
    do_stop();
    chk("clrn_set_stop", timer_clrn, 0);
    cyc(1);
    chk("timer_cleared", timer_val(), 0);
    n0 = ld_q.size();
    key(5); key(9); key(3);
    chk("load_count_593", ld_q.size() - n0, 2);
    chk("timer_59", timer_val(), 59);

    // Door open during cook, resume, stop twice
    do_stop();
    key(2); key(0);
    do_start();
    cyc(10);
    door_closed = 0;
    cyc(1);
    chk("mag_door_open", mag_on, 0);
    v = timer_val();
    cyc(8);
    chk("timer_frozen", timer_val(), v);
    door_closed = 1;
    cyc(1);
    do_start();
    chk("mag_resume", mag_on, 1);
    cyc(20);
    do_stop();
    chk("mag_stop_pause", mag_on, 0);
    cyc(1);
    do_stop();
    chk("clrn_pause_stop", timer_clrn, 0);
    cyc(1);
    chk("timer_clear_pause", timer_val(), 0);

    // Start with nothing entered
    do_start();
    chk("mag_idle_start", mag_on, 0);
    cyc(3);
    chk("mag_idle_start2", mag_on, 0);

`ifdef MWAVE_DONE_BEEP_EN
    // Alert cut short by stop_clear
    key(1);
    do_start();
    wait_beep(1, 60, "beep_rise_timeout");
    cyc(3);
    do_stop();
    chk("beep_stop_drop", beep, 0);
    cyc(2);
`endif

    // clr mid-cook
    key(5); key(0);
    do_start();
    cyc(7);
    clr = 1;
    cyc(1);
    chk("clr_mag",   mag_on,      0);
    chk("clr_en",    timer_en,    0);
    chk("clr_loadn", timer_loadn, 1);
    chk("clr_beep",  beep,        0);
    chk("clr_data",  timer_data,  0);
    chk("clr_clrn",  timer_clrn,  0);
    cyc(1);
    clr = 0;
    #1;
    chk("clrn_after_release", timer_clrn, 0);
    cyc(1);
    chk("clrn_high_again", timer_clrn, 1);
    chk("timer_clr_mid", timer_val(), 0);

    // Randomized front panel
    for (int i = 0; i < 4000; i++) begin
      key_valid  = ($urandom_range(0, 5) == 0);
      key_digit  = 4'($urandom_range(0, 11));
      start      = ($urandom_range(0, 14) == 0);
      stop_clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 79) == 0) door_closed = !door_closed;
      clr        = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    key_valid = 0; start = 0; stop_clear = 0; clr = 0; door_closed = 1;
    cyc(5);
    chk("en_spacing", gap_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
